// File: rtl/axicb_pkg.sv
// -----------------------------------------------------------------------------
// axicb_pkg
//   Shared types and helpers for the crossbar arbitration logic.
//   - AXICB_MAX_REQ : widest requester vector any arbiter/picker supports
//   - state_t       : arbiter FSM state (IDLE / LOCK)
//   - onehot2bin    : one-hot to binary index (zero input -> 0)
// -----------------------------------------------------------------------------
package axicb_pkg;

    localparam int AXICB_MAX_REQ = 8;
    localparam int AXICB_ID_W    = $clog2(AXICB_MAX_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic logic [AXICB_ID_W-1:0] onehot2bin(input logic [AXICB_MAX_REQ-1:0] oh);
        logic [AXICB_ID_W-1:0] b;
        b = '0;
        for (int i = 0; i < AXICB_MAX_REQ; i++) begin
            if (oh[i]) b = b | AXICB_ID_W'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/axicb_rr_picker.sv
// -----------------------------------------------------------------------------
// axicb_rr_picker
//   Combinational rotating priority encoder. Scans req starting at ptr and
//   wrapping modulo NB_REQ; the first set bit wins.
//   Ports:
//     req         in  [NB_REQ]  request vector
//     ptr         in  [REQ_W]   highest-priority index (< NB_REQ)
//     pick_onehot out [NB_REQ]  winner, one-hot (zero when no request)
//     pick_id     out [REQ_W]   winner, binary
//     pick_vld    out           any request present
// -----------------------------------------------------------------------------
module axicb_rr_picker
    import axicb_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int REQ_W  = $clog2(NB_REQ)
)(
    input  logic [NB_REQ-1:0] req,
    input  logic [REQ_W-1:0]  ptr,
    output logic [NB_REQ-1:0] pick_onehot,
    output logic [REQ_W-1:0]  pick_id,
    output logic              pick_vld
);

    always_comb begin
        int   idx;
        logic found;
        pick_onehot = '0;
        found       = 1'b0;
        idx         = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            // Explicit wrap instead of '%' so non-power-of-two NB_REQ works.
            idx = int'(ptr) + i;
            if (idx >= NB_REQ) idx = idx - NB_REQ;
            if (!found && req[REQ_W'(idx)]) begin
                pick_onehot[REQ_W'(idx)] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

    assign pick_vld = |req;
    assign pick_id  = REQ_W'(onehot2bin(AXICB_MAX_REQ'(pick_onehot)));

endmodule

// File: rtl/axicb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axicb_rr_arbiter
//   Round-robin arbiter sharing one crossbar master port between NB_REQ
//   requesters. A grant stays locked until the owning transaction reports
//   done; the released requester then drops to lowest priority and the next
//   grant is issued on the same edge (no bubble).
//   Optional feature (macro AXICB_ARB_TIMEOUT_EN): a lock lasting TIMEOUT
//   cycles without done is force-released and timeout_err is set (sticky).
//   Ports:
//     aclk         in            clock
//     arst         in            asynchronous reset, active-high
//     srst         in            synchronous reset, active-high
//     req          in  [NB_REQ]  per-requester request
//     done         in            completion of the granted transaction
//     grant        out [NB_REQ]  registered one-hot grant
//     grant_id     out [REQ_W]   binary index of grant
//     grant_vld    out           |grant
//     timeout_err  out           sticky forced-release flag (feature only)
// -----------------------------------------------------------------------------
module axicb_rr_arbiter
    import axicb_pkg::*;
#(
    parameter int NB_REQ  = 4,
    parameter int REQ_W   = $clog2(NB_REQ)
`ifdef AXICB_ARB_TIMEOUT_EN
   ,parameter int TIMEOUT = 1024
`endif
)(
    input  logic              aclk,
    input  logic              arst,
    input  logic              srst,
    input  logic [NB_REQ-1:0] req,
    input  logic              done,
    output logic [NB_REQ-1:0] grant,
    output logic [REQ_W-1:0]  grant_id,
    output logic              grant_vld
`ifdef AXICB_ARB_TIMEOUT_EN
   ,output logic              timeout_err
`endif
);

    state_t             state_q, state_d;
    logic [NB_REQ-1:0]  grant_q, grant_d;
    logic [REQ_W-1:0]   id_q, id_d;
    logic [REQ_W-1:0]   ptr_q, ptr_d;

    logic [REQ_W-1:0]   ptr_inc;
    logic [REQ_W-1:0]   pick_ptr;
    logic [NB_REQ-1:0]  pick_onehot;
    logic [REQ_W-1:0]   pick_id;
    logic               pick_vld;
    logic               tmo_hit;
    logic               rel;

`ifdef AXICB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;

    assign tmo_hit = (state_q == LOCK) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // A forced release behaves exactly like done.
    assign rel     = (state_q == LOCK) && (done || tmo_hit);
    assign ptr_inc = (id_q == REQ_W'(NB_REQ - 1)) ? '0 : id_q + REQ_W'(1);
    // On release the pick already sees the rotated pointer, which puts the
    // releasing requester last and lets a same-cycle new req compete.
    assign pick_ptr = rel ? ptr_inc : ptr_q;

    axicb_rr_picker #(
        .NB_REQ (NB_REQ),
        .REQ_W  (REQ_W)
    ) u_picker (
        .req         (req),
        .ptr         (pick_ptr),
        .pick_onehot (pick_onehot),
        .pick_id     (pick_id),
        .pick_vld    (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_onehot;
                    id_d    = pick_id;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (rel) begin
                    ptr_d = ptr_inc;
                    if (pick_vld) begin
                        grant_d = pick_onehot;
                        id_d    = pick_id;
                    end else begin
                        grant_d = '0;
                        id_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

`ifdef AXICB_ARB_TIMEOUT_EN
    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q | (tmo_hit & ~done);
        // Held at zero while idle, so entering LOCK starts from zero.
        if (state_q == IDLE || rel) cnt_d = '0;
        else                        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else if (srst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else if (srst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign grant_id  = id_q;
    assign grant_vld = |grant_q;

endmodule

// File: tb/tb_axicb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axicb_rr_arbiter
//   Directed, table-driven bench for axicb_rr_arbiter (NB_REQ=4). Each table
//   row gives the inputs for one cycle and the outputs expected after the
//   following rising edge. Hand-written sequences cover async reset mid-lock
//   and, with AXICB_ARB_TIMEOUT_EN, the forced release (TIMEOUT=16).
// -----------------------------------------------------------------------------
module tb_axicb_rr_arbiter;

    localparam int NB_REQ = 4;
    localparam int REQ_W  = 2;

    logic              aclk = 1'b0;
    logic              arst = 1'b1;
    logic              srst = 1'b0;
    logic [NB_REQ-1:0] req  = '0;
    logic              done = 1'b0;
    logic [NB_REQ-1:0] grant;
    logic [REQ_W-1:0]  grant_id;
    logic              grant_vld;
`ifdef AXICB_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axicb_rr_arbiter #(
        .NB_REQ (NB_REQ)
`ifdef AXICB_ARB_TIMEOUT_EN
       ,.TIMEOUT (16)
`endif
    ) dut (
        .aclk      (aclk),
        .arst      (arst),
        .srst      (srst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
`ifdef AXICB_ARB_TIMEOUT_EN
       ,.timeout_err (timeout_err)
`endif
    );

    typedef struct {
        logic [NB_REQ-1:0] req;
        logic              done;
        logic              srst;
        logic [NB_REQ-1:0] exp_grant;
        logic [REQ_W-1:0]  exp_id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [NB_REQ-1:0] r, input logic d, input logic s,
                       input logic [NB_REQ-1:0] g, input logic [REQ_W-1:0] id);
        vec_t v;
        v.req = r; v.done = d; v.srst = s; v.exp_grant = g; v.exp_id = id;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int idx, input logic [NB_REQ-1:0] g,
                           input logic [REQ_W-1:0] id);
        chk({nm, ".grant"}, idx, 32'(grant), 32'(g));
        chk({nm, ".grant_id"}, idx, 32'(grant_id), 32'(id));
        chk({nm, ".grant_vld"}, idx, 32'(grant_vld), 32'(g != '0));
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // ---- four requesters, done every 3rd cycle: 0,1,2,3,0 ----
        add(4'b1111, 0, 0, 4'b0001, 0);
        add(4'b1111, 0, 0, 4'b0001, 0);
        add(4'b1111, 0, 0, 4'b0001, 0);
        add(4'b1111, 1, 0, 4'b0010, 1);
        add(4'b1111, 0, 0, 4'b0010, 1);
        add(4'b1111, 0, 0, 4'b0010, 1);
        add(4'b1111, 1, 0, 4'b0100, 2);
        add(4'b1111, 0, 0, 4'b0100, 2);
        add(4'b1111, 0, 0, 4'b0100, 2);
        add(4'b1111, 1, 0, 4'b1000, 3);
        add(4'b1111, 0, 0, 4'b1000, 3);
        add(4'b1111, 0, 0, 4'b1000, 3);
        add(4'b1111, 1, 0, 4'b0001, 0);
        add(4'b0000, 1, 0, 4'b0000, 0);   // release, nobody waiting, ptr=1
        add(4'b0000, 0, 0, 4'b0000, 0);
        // ---- single requester 2, done every cycle, no bubble ----
        add(4'b0100, 0, 0, 4'b0100, 2);
        add(4'b0100, 1, 0, 4'b0100, 2);
        add(4'b0100, 1, 0, 4'b0100, 2);
        add(4'b0100, 1, 0, 4'b0100, 2);
        add(4'b0100, 1, 0, 4'b0100, 2);
        add(4'b0000, 1, 0, 4'b0000, 0);   // ptr=3
        add(4'b0000, 0, 0, 4'b0000, 0);
        // ---- 0 then 3 alternate; new req 3 arrives with done ----
        add(4'b0001, 0, 0, 4'b0001, 0);   // ptr 3 -> wraps to 0
        add(4'b1001, 1, 0, 4'b1000, 3);
        add(4'b1001, 1, 0, 4'b0001, 0);
        add(4'b1001, 1, 0, 4'b1000, 3);
        add(4'b0000, 1, 0, 4'b0000, 0);   // ptr=0
        add(4'b0000, 1, 0, 4'b0000, 0);   // done ignored in IDLE
        // ---- grantee drops req for 5 cycles; others ignored while locked ----
        add(4'b0010, 0, 0, 4'b0010, 1);
        add(4'b0000, 0, 0, 4'b0010, 1);
        add(4'b0000, 0, 0, 4'b0010, 1);
        add(4'b0101, 0, 0, 4'b0010, 1);
        add(4'b0000, 0, 0, 4'b0010, 1);
        add(4'b0000, 0, 0, 4'b0010, 1);
        add(4'b0000, 1, 0, 4'b0000, 0);   // ptr=2
        // ---- srst: clears grant and pointer ----
        add(4'b0001, 0, 0, 4'b0001, 0);
        add(4'b0001, 0, 1, 4'b0000, 0);
        add(4'b1010, 0, 0, 4'b0010, 1);   // ptr back at 0 -> 1 beats 3
        add(4'b0000, 1, 0, 4'b0000, 0);

        // ---- reset state ----
        step();
        step();
        chk_out("reset", 0, 4'b0000, 0);
        arst = 1'b0;

        foreach (vecs[i]) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            srst = vecs[i].srst;
            step();
            chk_out("vec", i, vecs[i].exp_grant, vecs[i].exp_id);
        end
        req = '0; done = 1'b0; srst = 1'b0;

        // ---- async reset mid-lock ----
        req = 4'b0010;
        step();
        chk_out("arst_pre", 0, 4'b0010, 1);
        #2 arst = 1'b1;
        #1 chk_out("arst_async", 0, 4'b0000, 0);
        #1 arst = 1'b0;
        req = 4'b0011;
        step();
        chk_out("arst_post", 0, 4'b0001, 0);
        done = 1'b1;
        req  = 4'b0000;
        step();
        chk_out("arst_rel", 0, 4'b0000, 0);
        done = 1'b0;

`ifdef AXICB_ARB_TIMEOUT_EN
        // ---- forced release after 16 locked cycles ----
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("terr_clr", 0, 32'(timeout_err), 0);
        req = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            step();
            chk_out("tmo_hold", c, 4'b0001, 0);
            chk("tmo_terr0", c, 32'(timeout_err), 0);
        end
        step();
        chk_out("tmo_rel", 0, 4'b0010, 1);
        chk("tmo_terr1", 0, 32'(timeout_err), 1);
        req = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_out("tmo_idle", 0, 4'b0000, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("tmo_sticky", c, 32'(timeout_err), 1);
        end
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("tmo_srst", 0, 32'(timeout_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axicb_rr_arbiter.md
Name: axicb_rr_arbiter

Overview:
- Round-robin arbiter that shares one crossbar master port between NB_REQ slave-port requesters (AW or AR channel).
- One instance per master port per address channel, inside axicb_crossbar_top.
- The grant is locked from selection until the owning transaction signals completion, so a burst is never interleaved.
- Fairness: the last-served requester drops to lowest priority.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- REQ_W, $clog2(NB_REQ), width of grant_id.
- TIMEOUT, 1024, cycles a grant may stay locked before a forced release (optional feature only).

Ports:
- aclk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- srst  in  1  synchronous reset, active-high; same reset values as arst.
- req  in  NB_REQ  per-requester request (valid of the slave-port address channel).
- done  in  1  completion of the granted transaction (e.g. wlast&wvalid&wready or rlast handshake).
- grant  out  NB_REQ  one-hot grant, registered.
- grant_id  out  REQ_W  binary index of grant.
- grant_vld  out  1  grant is active (|grant).
- timeout_err  out  1  sticky forced-release flag; exists only with the optional feature.

Behaviour:
- Reset values: grant=0, grant_id=0, grant_vld=0, ptr=0, state=IDLE, timeout_err=0.
  - Requester 0 therefore wins first after reset.
- ptr is the highest-priority index.
  - Pick = first set req bit scanning ptr, ptr+1, … with wrap modulo NB_REQ.
- IDLE state:
  - If req != 0, the picked requester is registered into grant/grant_id and grant_vld=1 on the next edge; go to LOCK.
  - Latency is 1 cycle from req to grant.
  - done is ignored.
- LOCK state:
  - Grant is held regardless of req.
  - A granted requester deasserting req does not release the grant (AXI valid must not drop).
- done=1 in LOCK:
  - ptr <= grant_id+1, wrapping NB_REQ-1 -> 0.
  - The same edge evaluates a new pick using the updated ptr over the current req, with the releasing requester included at lowest priority.
  - If the pick is non-zero: new grant on the next edge, stay in LOCK (back-to-back, no bubble).
  - Otherwise: grant=0, grant_vld=0, go to IDLE.
- Single requester, continuous: re-granted every done with no idle cycle.
- done and new req arriving in the same cycle: the new req takes part in that pick.
- grant is always one-hot or zero; grant_vld == |grant at all times.
- arst mid-LOCK: immediate return to reset values; the in-flight transaction is the crossbar's responsibility.
- srst: same reset values as arst, applied at the next edge.

Optional Feature:
- Macro AXICB_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT+1)) clears on entering LOCK and on done, and increments each LOCK cycle.
  - On reaching TIMEOUT-1 without done, the arbiter behaves as if done=1 that cycle (forced release and rotate) and sets timeout_err=1.
  - timeout_err is sticky until arst/srst.
- Not defined:
  - No counter.
  - timeout_err port absent.
  - Grant locks indefinitely until done.

Decomposition:
- axicb_pkg holds:
  - AXICB_MAX_REQ=8.
  - typedef state_t {IDLE, LOCK}.
  - Function onehot2bin.
- Sub-module axicb_rr_picker: purely combinational masked priority encoder.
  - Inputs: req, ptr.
  - Outputs: pick_onehot, pick_id, pick_vld.
  - Reused by the response-path mux.

Test Plan:
- Reset then req=4'b1111, done pulsed every 3rd cycle -> grant_id sequence 0,1,2,3,0; each grant held exactly until done; no bubble between grants.
- req=4'b0100 only, done every cycle -> grant=4'b0100 continuously, grant_vld never drops, ptr cycles to 3.
- req=4'b1001 after grant 0 completes -> next grant 3, then 0; requester 0 does not win twice while 3 waits.
- Granted requester drops req for 5 cycles before done -> grant unchanged for those cycles; release only on done.
- arst asserted mid-LOCK with grant=4'b0010 -> grant=0 and grant_vld=0 immediately (async); after reset, req=4'b0011 -> grant 0.
- AXICB_ARB_TIMEOUT_EN, TIMEOUT=16, req=4'b0011, done never asserted -> grant 0 for 16 cycles, then grant 1, timeout_err=1 and stays 1 until srst.
